// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIF FFT sequencer.
// State encoding plus bit-reversal used for natural-order unload.
package fft_pkg;

    localparam int MAXLOG = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN,
        UNLOAD
    } state_t;

    // Reverses the low n bits of v; bits at and above n return 0.
    function automatic logic [MAXLOG-1:0] bitrev(
        input logic [MAXLOG-1:0] v,
        input int                n
    );
        logic [MAXLOG-1:0] r;
        r = '0;
        for (int i = 0; i < MAXLOG; i++) begin
            if (i < n) r[i] = v[n-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Stream, RAM-address and butterfly-control bundle for fft_seq_ctrl.
// master is the controller side, slave is the surrounding datapath.
interface fft_seq_ctrl_if #(
    parameter int LOGN = 3
);
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic            out_ready;
    logic            out_valid;
    logic            ram_wr_en;
    logic [LOGN-1:0] ram_wr_addr_a;
    logic [LOGN-1:0] ram_wr_addr_b;
    logic [LOGN-1:0] ram_rd_addr_a;
    logic [LOGN-1:0] ram_rd_addr_b;
    logic            bfly_en;
    logic [LOGN-2:0] tw_index;
    logic [LOGN-1:0] stage;
    logic            busy;
    logic            frame_done;

    modport master (
        input  start, in_valid, out_ready,
        output in_ready, out_valid, ram_wr_en,
        output ram_wr_addr_a, ram_wr_addr_b,
        output ram_rd_addr_a, ram_rd_addr_b,
        output bfly_en, tw_index, stage,
        output busy, frame_done
    );

    modport slave (
        output start, in_valid, out_ready,
        input  in_ready, out_valid, ram_wr_en,
        input  ram_wr_addr_a, ram_wr_addr_b,
        input  ram_rd_addr_a, ram_rd_addr_b,
        input  bfly_en, tw_index, stage,
        input  busy, frame_done
    );

endinterface

// File: rtl/fft_addr_gen.sv
// Combinational DIF butterfly address and twiddle index generator.
// Maps (stage, butterfly) to the operand pair and W_N^k index.
module fft_addr_gen #(
    parameter int LOGN = 3
) (
    input  logic [LOGN-1:0] i_stage,
    input  logic [LOGN-2:0] i_b,
    output logic [LOGN-1:0] o_addr_a,
    output logic [LOGN-1:0] o_addr_b,
    output logic [LOGN-2:0] o_tw
);

    localparam logic [LOGN-1:0] TOP = LOGN'(LOGN - 1);
    localparam logic [LOGN-1:0] ONE = LOGN'(1);

    logic [LOGN-1:0] w_sh;
    logic [LOGN-1:0] w_span;
    logic [LOGN-2:0] w_mask;
    logic [LOGN-2:0] w_pos;
    logic [LOGN-2:0] w_grp;

    assign w_sh   = TOP - i_stage;
    assign w_span = ONE << w_sh;
    // At stage 0 span is N/2, whose low bits are zero, so the mask wraps to all ones.
    assign w_mask = w_span[LOGN-2:0] - 1'b1;
    assign w_pos  = i_b & w_mask;
    assign w_grp  = i_b >> w_sh;

    assign o_addr_a = ({1'b0, w_grp} << (w_sh + ONE)) | {1'b0, w_pos};
    assign o_addr_b = o_addr_a | w_span;
    assign o_tw     = w_pos << i_stage;

endmodule

// File: rtl/fft_seq_ctrl.sv
// Load / compute / unload sequencer for an in-place radix-2 DIF FFT.
// Owns the FSM, counters and the butterfly write-back delay line.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int N        = 8,
    parameter int LOGN     = 3,
    parameter int PIPE_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    fft_seq_ctrl_if.master bus
);

    localparam int DW = $clog2(PIPE_LAT + 1);
    localparam logic [LOGN-1:0] CNT_LAST = LOGN'(N - 1);
    localparam logic [LOGN-2:0] B_LAST   = (LOGN-1)'(N/2 - 1);
    localparam logic [LOGN-1:0] S_LAST   = LOGN'(LOGN - 1);
    localparam logic [DW-1:0]   D_LAST   = DW'(PIPE_LAT - 1);

    state_t          r_state;
    logic [LOGN-1:0] r_cnt;
    logic [LOGN-1:0] r_stage;
    logic [LOGN-2:0] r_b;
    logic [DW-1:0]   r_drain;
    logic            r_frame_done;

    logic [PIPE_LAT-1:0] r_wb_vld;
    logic [LOGN-1:0]     r_wb_a [PIPE_LAT];
    logic [LOGN-1:0]     r_wb_b [PIPE_LAT];

    logic            w_bfly;
    logic            w_load;
    logic            w_wb;
    logic [LOGN-1:0] w_rd_a;
    logic [LOGN-1:0] w_rd_b;
    logic [LOGN-2:0] w_tw;
    logic [LOGN-1:0] w_rev;

    fft_addr_gen #(.LOGN(LOGN)) u_addr_gen (
        .i_stage  (r_stage),
        .i_b      (r_b),
        .o_addr_a (w_rd_a),
        .o_addr_b (w_rd_b),
        .o_tw     (w_tw)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_stage      <= '0;
            r_b          <= '0;
            r_drain      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) r_state <= LOAD;
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= COMPUTE;
                            r_cnt   <= '0;
                            r_stage <= '0;
                            r_b     <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    r_b <= r_b + 1'b1;
                    if (r_b == B_LAST) begin
                        r_state <= DRAIN;
                        r_b     <= '0;
                        r_drain <= '0;
                    end
                end
                DRAIN: begin
                    r_drain <= r_drain + 1'b1;
                    if (r_drain == D_LAST) begin
                        if (r_stage == S_LAST) begin
                            r_state <= UNLOAD;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= COMPUTE;
                            r_stage <= r_stage + 1'b1;
                        end
                    end
                end
                UNLOAD: begin
                    if (bus.out_ready) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_state      <= IDLE;
                            r_cnt        <= '0;
                            r_stage      <= '0;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operand addresses re-emerge as write-back addresses PIPE_LAT cycles later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wb_vld <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_wb_a[i] <= '0;
                r_wb_b[i] <= '0;
            end
        end else begin
            r_wb_vld[0] <= w_bfly;
            r_wb_a[0]   <= w_rd_a;
            r_wb_b[0]   <= w_rd_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_wb_vld[i] <= r_wb_vld[i-1];
                r_wb_a[i]   <= r_wb_a[i-1];
                r_wb_b[i]   <= r_wb_b[i-1];
            end
        end
    end

    assign w_bfly = (r_state == COMPUTE);
    assign w_load = bus.in_ready & bus.in_valid;
    assign w_wb   = r_wb_vld[PIPE_LAT-1];
    assign w_rev  = LOGN'(bitrev({{(MAXLOG-LOGN){1'b0}}, r_cnt}, LOGN));

    assign bus.in_ready  = (r_state == LOAD);
    assign bus.out_valid = (r_state == UNLOAD);
    assign bus.busy      = (r_state != IDLE);
    assign bus.bfly_en   = w_bfly;
    assign bus.stage     = r_stage;
    assign bus.tw_index  = w_bfly ? w_tw : '0;
    assign bus.frame_done = r_frame_done;

    assign bus.ram_wr_en     = w_load | w_wb;
    assign bus.ram_wr_addr_a = w_load ? r_cnt :
                               (w_wb ? r_wb_a[PIPE_LAT-1] : '0);
    assign bus.ram_wr_addr_b = w_wb ? r_wb_b[PIPE_LAT-1] : '0;

    assign bus.ram_rd_addr_a = w_bfly ? w_rd_a :
                               (bus.out_valid ? w_rev : '0);
    assign bus.ram_rd_addr_b = w_bfly ? w_rd_b : '0;

endmodule
